// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: C-instruction jump encodings and the PC halt-detector state type.
// Imported by the program-counter slice and, later, by the decode stage.
package hack_pkg;

    localparam logic [2:0] JNULL = 3'b000;
    localparam logic [2:0] JGT   = 3'b001;
    localparam logic [2:0] JEQ   = 3'b010;
    localparam logic [2:0] JGE   = 3'b011;
    localparam logic [2:0] JLT   = 3'b100;
    localparam logic [2:0] JNE   = 3'b101;
    localparam logic [2:0] JLE   = 3'b110;
    localparam logic [2:0] JMP   = 3'b111;

    typedef enum logic {PC_RUN, PC_HALT} pc_state_t;

endpackage

// File: rtl/pc_jump_unit_if.sv
// Bus between the fetch/decode side and the program counter: jump request, flags and stall in,
// registered PC, taken pulse, halt flag and FSM state out.
interface pc_jump_unit_if #(parameter int WIDTH = 16);
    import hack_pkg::*;

    logic [WIDTH-1:0] a_in;
    logic [2:0]       jump_bits;
    logic             is_c_inst;
    logic             zr;
    logic             ng;
    logic             stall;
    logic [WIDTH-1:0] pc_out;
    logic             taken;
    logic             halted;
    pc_state_t        state_dbg;

    // No valid/ready pair here: the PC consumes its inputs on every non-stalled rising edge,
    // and stall=1 discards whatever request is presented that cycle.
    modport master (
        output a_in, jump_bits, is_c_inst, zr, ng, stall,
        input  pc_out, taken, halted, state_dbg
    );

    modport slave (
        input  a_in, jump_bits, is_c_inst, zr, ng, stall,
        output pc_out, taken, halted, state_dbg
    );

endinterface

// File: rtl/pc_jump_unit_jump_cond.sv
// Combinational jump decision from the C-instruction jump bits {j1,j2,j3} and the ALU flags.
module jump_cond (
    input  logic [2:0] jump_bits,
    input  logic       zr,
    input  logic       ng,
    input  logic       is_c_inst,
    output logic       take
);

    // j1: result < 0, j2: result == 0, j3: result > 0
    always_comb begin
        take = is_c_inst & ((jump_bits[2] & ng) |
                            (jump_bits[1] & zr) |
                            (jump_bits[0] & ~zr & ~ng));
    end

endmodule

// File: rtl/pc_jump_unit.sv
// Hack program counter with jump evaluation; define PC_HALT_DETECT_EN to add the
// self-loop ("@END; 0;JMP") halt detector FSM.
module pc_jump_unit
    import hack_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int HALT_COUNT = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    pc_jump_unit_if.slave   bus
);

    logic             take;
    logic             run;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             taken_q, taken_d;

    jump_cond u_jump_cond (
        .jump_bits (bus.jump_bits),
        .zr        (bus.zr),
        .ng        (bus.ng),
        .is_c_inst (bus.is_c_inst),
        .take      (take)
    );

`ifdef PC_HALT_DETECT_EN
    localparam int CNT_W = $clog2(HALT_COUNT + 1);

    pc_state_t         state_q, state_d;
    logic [CNT_W-1:0]  selfcnt_q, selfcnt_d;
    logic              halted_q, halted_d;
    logic              self_jump;

    always_comb begin
        state_d   = state_q;
        selfcnt_d = selfcnt_q;
        halted_d  = halted_q;
        self_jump = take & (bus.a_in == pc_q) & ~bus.stall;
        // HALT is terminal; stalled cycles leave the count untouched.
        if (state_q == PC_RUN && !bus.stall) begin
            if (self_jump) begin
                if (int'(selfcnt_q) < HALT_COUNT) begin
                    selfcnt_d = selfcnt_q + CNT_W'(1);
                end
                if (int'(selfcnt_q) + 1 >= HALT_COUNT) begin
                    state_d  = PC_HALT;
                    halted_d = 1'b1;
                end
            end else begin
                selfcnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= PC_RUN;
            selfcnt_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            selfcnt_q <= selfcnt_d;
            halted_q  <= halted_d;
        end
    end

    assign run           = (state_q == PC_RUN);
    assign bus.halted    = halted_q;
    assign bus.state_dbg = state_q;
`else
    assign run           = 1'b1;
    assign bus.halted    = 1'b0;
    assign bus.state_dbg = PC_RUN;
`endif

    // Priority: stall > halted > jump > increment.
    always_comb begin
        pc_d    = pc_q;
        taken_d = taken_q;
        if (!bus.stall) begin
            if (!run) begin
                taken_d = 1'b0;
            end else if (take) begin
                pc_d    = bus.a_in;
                taken_d = 1'b1;
            end else begin
                pc_d    = pc_q + WIDTH'(1);
                taken_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            taken_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    assign bus.pc_out = pc_q;
    assign bus.taken  = taken_q;

endmodule

// File: tb/tb_pc_jump_unit.sv
// Directed bench for pc_jump_unit: table of jump-encoding x flag vectors plus hand-written
// sequences for wrap, stall, async reset and (with PC_HALT_DETECT_EN) self-loop halt.
module tb_pc_jump_unit;
    import hack_pkg::*;

    localparam int W = 16;
`ifdef PC_HALT_DETECT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0] jb;
        logic       zr;
        logic       ng;
        logic       take;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pc_jump_unit_if #(.WIDTH(W)) bus();

    pc_jump_unit #(.WIDTH(W), .HALT_COUNT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_pc;
    logic [W-1:0] exp_q[$];
    vec_t vecs[24];

    task automatic check_pc(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic [2:0] j, input logic z, input logic n,
                         input logic [W-1:0] a, input logic s);
        bus.is_c_inst = c;
        bus.jump_bits = j;
        bus.zr        = z;
        bus.ng        = n;
        bus.a_in      = a;
        bus.stall     = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {jump_bits, zr, ng, expected take}, worked out by hand from j1&ng | j2&zr | j3&~zr&~ng
        vecs[0]  = '{JNULL, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{JGT,   1'b1, 1'b0, 1'b0};
        vecs[2]  = '{JEQ,   1'b1, 1'b0, 1'b1};
        vecs[3]  = '{JGE,   1'b1, 1'b0, 1'b1};
        vecs[4]  = '{JLT,   1'b1, 1'b0, 1'b0};
        vecs[5]  = '{JNE,   1'b1, 1'b0, 1'b0};
        vecs[6]  = '{JLE,   1'b1, 1'b0, 1'b1};
        vecs[7]  = '{JMP,   1'b1, 1'b0, 1'b1};
        vecs[8]  = '{JNULL, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{JGT,   1'b0, 1'b1, 1'b0};
        vecs[10] = '{JEQ,   1'b0, 1'b1, 1'b0};
        vecs[11] = '{JGE,   1'b0, 1'b1, 1'b0};
        vecs[12] = '{JLT,   1'b0, 1'b1, 1'b1};
        vecs[13] = '{JNE,   1'b0, 1'b1, 1'b1};
        vecs[14] = '{JLE,   1'b0, 1'b1, 1'b1};
        vecs[15] = '{JMP,   1'b0, 1'b1, 1'b1};
        vecs[16] = '{JNULL, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{JGT,   1'b0, 1'b0, 1'b1};
        vecs[18] = '{JEQ,   1'b0, 1'b0, 1'b0};
        vecs[19] = '{JGE,   1'b0, 1'b0, 1'b1};
        vecs[20] = '{JLT,   1'b0, 1'b0, 1'b0};
        vecs[21] = '{JNE,   1'b0, 1'b0, 1'b1};
        vecs[22] = '{JLE,   1'b0, 1'b0, 1'b0};
        vecs[23] = '{JMP,   1'b0, 1'b0, 1'b1};

        // Reset state
        reset_n = 1'b0;
        drive(1'b0, JNULL, 1'b0, 1'b0, '0, 1'b0);
        #12;
        check_pc("reset_pc", bus.pc_out, 16'h0000);
        check_bit("reset_taken", bus.taken, 1'b0);
        check_bit("reset_halted", bus.halted, 1'b0);
        check_bit("reset_state", bus.state_dbg, PC_RUN);
        @(negedge clk);
        reset_n = 1'b1;

        // Plain increment 1..10
        for (int i = 1; i <= 10; i++) begin
            step();
            check_pc("incr_pc", bus.pc_out, W'(i));
            check_bit("incr_taken", bus.taken, 1'b0);
        end

        // JEQ taken with zr=1, then not taken with zr=0 from pc=10
        drive(1'b1, JEQ, 1'b1, 1'b0, 16'h0100, 1'b0);
        step();
        check_pc("jeq_taken_pc", bus.pc_out, 16'h0100);
        check_bit("jeq_taken_flag", bus.taken, 1'b1);
        drive(1'b1, JMP, 1'b0, 1'b0, 16'd10, 1'b0);
        step();
        check_pc("jmp_back_pc", bus.pc_out, 16'd10);
        drive(1'b1, JEQ, 1'b0, 1'b0, 16'h0100, 1'b0);
        step();
        check_pc("jeq_not_taken_pc", bus.pc_out, 16'd11);
        check_bit("jeq_not_taken_flag", bus.taken, 1'b0);
        exp_pc = 16'd11;

        // All jump encodings x three flag sets
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] tgt;
            logic [W-1:0] e;
            tgt = 16'h0200 + W'(i * 4);
            drive(1'b1, vecs[i].jb, vecs[i].zr, vecs[i].ng, tgt, 1'b0);
            exp_q.push_back(vecs[i].take ? tgt : exp_pc + 16'd1);
            step();
            e = exp_q.pop_front();
            check_bit("vec_taken", bus.taken, vecs[i].take);
            check_pc("vec_pc", bus.pc_out, e);
            exp_pc = e;
        end

        // is_c_inst=0 masks an unconditional jump
        drive(1'b0, JMP, 1'b0, 1'b0, 16'h0777, 1'b0);
        step();
        check_pc("a_inst_pc", bus.pc_out, exp_pc + 16'd1);
        check_bit("a_inst_taken", bus.taken, 1'b0);

        // Wrap from FFFF to 0000
        drive(1'b1, JMP, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        step();
        check_pc("wrap_load", bus.pc_out, 16'hFFFF);
        drive(1'b0, JNULL, 1'b0, 1'b0, 16'h0000, 1'b0);
        step();
        check_pc("wrap_pc", bus.pc_out, 16'h0000);
        check_bit("wrap_taken", bus.taken, 1'b0);

        // Stall drops the jump; releasing with the jump still presented takes it
        drive(1'b1, JMP, 1'b0, 1'b0, 16'h0020, 1'b1);
        step();
        check_pc("stall_pc", bus.pc_out, 16'h0000);
        check_bit("stall_taken", bus.taken, 1'b0);
        step();
        check_pc("stall2_pc", bus.pc_out, 16'h0000);
        bus.stall = 1'b0;
        step();
        check_pc("unstall_pc", bus.pc_out, 16'h0020);
        check_bit("unstall_taken", bus.taken, 1'b1);

        // Stall holds taken=1 too
        drive(1'b0, JNULL, 1'b0, 1'b0, 16'h0000, 1'b1);
        step();
        check_bit("stall_hold_taken", bus.taken, 1'b1);
        check_pc("stall_hold_pc", bus.pc_out, 16'h0020);
        bus.stall = 1'b0;
        step();
        check_pc("after_stall_pc", bus.pc_out, 16'h0021);

        // Asynchronous reset mid-operation
        #2;
        reset_n = 1'b0;
        #1;
        check_pc("async_reset_pc", bus.pc_out, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        // Self-loop at 0x42: four self-jumps with a stall in the middle
        drive(1'b1, JMP, 1'b0, 1'b0, 16'h0042, 1'b0);
        step();
        check_pc("loop_entry_pc", bus.pc_out, 16'h0042);
        step();
        check_bit("self1_halted", bus.halted, 1'b0);
        step();
        check_bit("self2_halted", bus.halted, 1'b0);
        bus.stall = 1'b1;
        step();
        check_bit("self_stall_halted", bus.halted, 1'b0);
        bus.stall = 1'b0;
        step();
        check_bit("self3_halted", bus.halted, 1'b0);
        check_pc("self3_pc", bus.pc_out, 16'h0042);
        step();
        check_bit("self4_halted", bus.halted, HALT_EN);
        check_bit("self4_taken", bus.taken, 1'b1);
        check_bit("self4_state", bus.state_dbg, HALT_EN ? PC_HALT : PC_RUN);

        // Once halted, inputs are ignored
        drive(1'b1, JMP, 1'b0, 1'b0, 16'h0099, 1'b0);
        step();
        check_pc("post_halt_jmp_pc", bus.pc_out, HALT_EN ? 16'h0042 : 16'h0099);
        check_bit("post_halt_jmp_taken", bus.taken, ~HALT_EN);
        drive(1'b0, JNULL, 1'b0, 1'b0, 16'h0000, 1'b0);
        step();
        check_pc("post_halt_incr_pc", bus.pc_out, HALT_EN ? 16'h0042 : 16'h009A);
        check_bit("post_halt_halted", bus.halted, HALT_EN);

        // Reset exits HALT immediately
        #2;
        reset_n = 1'b0;
        #1;
        check_pc("halt_reset_pc", bus.pc_out, 16'h0000);
        check_bit("halt_reset_halted", bus.halted, 1'b0);
        check_bit("halt_reset_taken", bus.taken, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_pc("restart_pc", bus.pc_out, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
